// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcode, immediate, ALU-op and state definitions for the core sequencer
package core_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    // 2'b00 is deliberately unused: the immediate sub-controller does not decode it
    localparam logic [1:0] IMM_I = 2'b10;
    localparam logic [1:0] IMM_B = 2'b01;
    localparam logic [1:0] IMM_U = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_R    = 3'd0,
        C_I    = 3'd1,
        C_LOAD = 3'd2,
        C_BR   = 3'd3,
        C_LUI  = 3'd4
    } iclass_t;

endpackage

// File: rtl/mem_wdog.sv
// rtl/mem_wdog.sv - saturating watchdog on an outstanding memory request
module mem_wdog #(
    parameter int TMO_W   = 8,
    parameter int TMO_LIM = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ready,
    output logic timeout
);

    localparam logic [TMO_W-1:0] LIM_M1 = TMO_W'(TMO_LIM - 1);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !req || ready) begin
            cnt <= '0;
        end else if (cnt != {TMO_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires on the TMO_LIM-th unanswered cycle; a ready in that same cycle wins.
    assign timeout = req && !ready && (cnt >= LIM_M1);

endmodule

// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core
module core_seq_ctrl
    import core_pkg::*;
#(
    parameter int TMO_W   = 8,
    parameter int TMO_LIM = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_ifetch,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic [1:0] imm_ctr,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       wb_sel,
    output logic       reg_we,
    output logic       trap,
    output logic       trap_cause
);

    state_t     state, state_nxt;
    iclass_t    cls_q, dec_cls;
    logic [1:0] imm_q, dec_imm;
    logic       asb_q, dec_asb;
    logic [1:0] aop_q, dec_aop;
    logic       dec_legal;
    logic       cause_q, cause_nxt;
    logic       timeout;

    logic mem_req_c, mem_ifetch_c, ir_we_c, pc_we_c, pc_src_c, wb_sel_c, reg_we_c;

    mem_wdog #(
        .TMO_W   (TMO_W),
        .TMO_LIM (TMO_LIM)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .req     (mem_req),
        .ready   (mem_ready),
        .timeout (timeout)
    );

    always_comb begin
        dec_legal = 1'b1;
        dec_cls   = C_R;
        dec_imm   = imm_q;
        dec_asb   = 1'b0;
        dec_aop   = ALU_FUNCT;
        case (opcode)
            OP_R:    begin dec_cls = C_R;                                                        end
            OP_I:    begin dec_cls = C_I;    dec_imm = IMM_I; dec_asb = 1'b1; dec_aop = ALU_FUNCT; end
            OP_LOAD: begin dec_cls = C_LOAD; dec_imm = IMM_I; dec_asb = 1'b1; dec_aop = ALU_ADD;   end
            OP_BR:   begin dec_cls = C_BR;   dec_imm = IMM_B; dec_asb = 1'b0; dec_aop = ALU_SUB;   end
            OP_LUI:  begin dec_cls = C_LUI;  dec_imm = IMM_U; dec_asb = 1'b1; dec_aop = ALU_PASSB; end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        cause_nxt    = cause_q;
        mem_req_c    = 1'b0;
        mem_ifetch_c = 1'b0;
        ir_we_c      = 1'b0;
        pc_we_c      = 1'b0;
        pc_src_c     = 1'b0;
        wb_sel_c     = 1'b0;
        reg_we_c     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req_c    = 1'b1;
                mem_ifetch_c = 1'b1;
                if (timeout) begin
                    state_nxt = S_TRAP;
                    cause_nxt = 1'b1;
                end else if (mem_ready) begin
                    ir_we_c   = 1'b1;
                    pc_we_c   = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    state_nxt = S_EXEC;
                end else begin
                    state_nxt = S_TRAP;
                    cause_nxt = 1'b0;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_BR: begin
                        pc_we_c   = alu_zero;
                        pc_src_c  = alu_zero;
                        state_nxt = S_FETCH;
                    end
                    C_LOAD:  state_nxt = S_MEM;
                    default: state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                if (timeout) begin
                    state_nxt = S_TRAP;
                    cause_nxt = 1'b1;
                end else if (mem_ready) begin
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                reg_we_c  = 1'b1;
                wb_sel_c  = (cls_q == C_LOAD);
                state_nxt = S_FETCH;
            end
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            cls_q   <= C_R;
            imm_q   <= IMM_I;
            asb_q   <= 1'b0;
            aop_q   <= ALU_ADD;
            cause_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
            if (state == S_DECODE && dec_legal) begin
                cls_q <= dec_cls;
                imm_q <= dec_imm;
                asb_q <= dec_asb;
                aop_q <= dec_aop;
            end
        end
    end

    // Reset masks every output so an interrupted instruction issues no partial write.
    assign mem_req    = !rst && mem_req_c;
    assign mem_ifetch = !rst && mem_ifetch_c;
    assign ir_we      = !rst && ir_we_c;
    assign pc_we      = !rst && pc_we_c;
    assign pc_src     = !rst && pc_src_c;
    assign wb_sel     = !rst && wb_sel_c;
    assign reg_we     = !rst && reg_we_c;
    assign imm_ctr    = rst ? IMM_I : imm_q;
    assign alu_src_b  = !rst && asb_q;
    assign alu_op     = rst ? ALU_ADD : aop_q;
    assign trap       = !rst && (state == S_TRAP);
    assign trap_cause = !rst && cause_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - table-driven bench for core_seq_ctrl plus watchdog sequences
module tb_core_seq_ctrl;

    localparam int TMO_W   = 8;
    localparam int TMO_LIM = 200;

    localparam logic [6:0] OPR   = 7'b0110011;
    localparam logic [6:0] OPI   = 7'b0010011;
    localparam logic [6:0] OPLD  = 7'b0000011;
    localparam logic [6:0] OPBR  = 7'b1100011;
    localparam logic [6:0] OPLUI = 7'b0110111;
    localparam logic [6:0] OPBAD = 7'b1111111;

    // enable groups: {mem_req, mem_ifetch, ir_we, pc_we, pc_src}
    localparam logic [4:0] FE = 5'b11110;
    localparam logic [4:0] FW = 5'b11000;
    localparam logic [4:0] NO = 5'b00000;
    localparam logic [4:0] BT = 5'b00011;
    localparam logic [4:0] MM = 5'b10000;

    typedef struct packed {
        logic       mem_req;
        logic       mem_ifetch;
        logic       ir_we;
        logic       pc_we;
        logic       pc_src;
        logic [1:0] imm_ctr;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       wb_sel;
        logic       reg_we;
        logic       trap;
        logic       trap_cause;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [6:0] opcode;
        logic       alu_zero;
        logic       mem_ready;
        outs_t      exp;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req, mem_ifetch, ir_we, pc_we, pc_src;
    logic [1:0] imm_ctr;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       wb_sel, reg_we, trap, trap_cause;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    core_seq_ctrl #(
        .TMO_W   (TMO_W),
        .TMO_LIM (TMO_LIM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_ifetch (mem_ifetch),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .imm_ctr    (imm_ctr),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .wb_sel     (wb_sel),
        .reg_we     (reg_we),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    function automatic outs_t o(input logic [4:0] en, input logic [1:0] imm, input logic asb,
                                input logic [1:0] aop, input logic [3:0] tail);
        return {en, imm, asb, aop, tail};
    endfunction

    task automatic add(input logic r, input logic [6:0] op, input logic z, input logic rdy,
                       input outs_t e, input string n);
        vec_t v;
        v.rst = r; v.opcode = op; v.alu_zero = z; v.mem_ready = rdy; v.exp = e; v.name = n;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic outs_t act_outs();
        return {mem_req, mem_ifetch, ir_we, pc_we, pc_src, imm_ctr, alu_src_b, alu_op,
                wb_sel, reg_we, trap, trap_cause};
    endfunction

    initial begin
        // tail = {wb_sel, reg_we, trap, trap_cause}
        add(1, OPI,  0, 1, o(NO, 2'b10, 0, 2'b00, 4'b0000), "reset");
        add(0, OPI,  0, 1, o(FE, 2'b10, 0, 2'b00, 4'b0000), "i_fetch");
        add(0, OPI,  0, 1, o(NO, 2'b10, 0, 2'b00, 4'b0000), "i_decode");
        add(0, OPI,  0, 1, o(NO, 2'b10, 1, 2'b10, 4'b0000), "i_exec");
        add(0, OPI,  0, 1, o(NO, 2'b10, 1, 2'b10, 4'b0100), "i_wb");
        add(0, OPBR, 1, 1, o(FE, 2'b10, 1, 2'b10, 4'b0000), "br_fetch");
        add(0, OPBR, 1, 1, o(NO, 2'b10, 1, 2'b10, 4'b0000), "br_decode");
        add(0, OPBR, 1, 1, o(BT, 2'b01, 0, 2'b01, 4'b0000), "br_taken");
        add(0, OPBR, 0, 1, o(FE, 2'b01, 0, 2'b01, 4'b0000), "br2_fetch");
        add(0, OPBR, 0, 1, o(NO, 2'b01, 0, 2'b01, 4'b0000), "br2_decode");
        add(0, OPBR, 0, 1, o(NO, 2'b01, 0, 2'b01, 4'b0000), "br_not_taken");
        add(0, OPLUI,0, 1, o(FE, 2'b01, 0, 2'b01, 4'b0000), "lui_fetch");
        add(0, OPLUI,0, 1, o(NO, 2'b01, 0, 2'b01, 4'b0000), "lui_decode");
        add(0, OPLUI,0, 1, o(NO, 2'b11, 1, 2'b11, 4'b0000), "lui_exec");
        add(0, OPLUI,0, 1, o(NO, 2'b11, 1, 2'b11, 4'b0100), "lui_wb");
        add(0, OPLD, 0, 1, o(FE, 2'b11, 1, 2'b11, 4'b0000), "ld_fetch");
        add(0, OPLD, 0, 1, o(NO, 2'b11, 1, 2'b11, 4'b0000), "ld_decode");
        add(0, OPLD, 0, 1, o(NO, 2'b10, 1, 2'b00, 4'b0000), "ld_exec");
        add(0, OPLD, 0, 0, o(MM, 2'b10, 1, 2'b00, 4'b0000), "ld_mem_wait");
        add(0, OPLD, 0, 1, o(MM, 2'b10, 1, 2'b00, 4'b0000), "ld_mem_done");
        add(0, OPLD, 0, 1, o(NO, 2'b10, 1, 2'b00, 4'b1100), "ld_wb");
        add(0, OPR,  0, 1, o(FE, 2'b10, 1, 2'b00, 4'b0000), "r_fetch");
        add(0, OPR,  0, 1, o(NO, 2'b10, 1, 2'b00, 4'b0000), "r_decode");
        add(0, OPR,  0, 1, o(NO, 2'b10, 0, 2'b10, 4'b0000), "r_exec");
        add(0, OPR,  0, 1, o(NO, 2'b10, 0, 2'b10, 4'b0100), "r_wb");
        add(0, OPBAD,0, 1, o(FE, 2'b10, 0, 2'b10, 4'b0000), "bad_fetch");
        add(0, OPBAD,0, 1, o(NO, 2'b10, 0, 2'b10, 4'b0000), "bad_decode");
        add(0, OPBAD,0, 1, o(NO, 2'b10, 0, 2'b10, 4'b0010), "illegal_trap");
        add(0, OPBAD,0, 1, o(NO, 2'b10, 0, 2'b10, 4'b0010), "trap_hold");
        add(1, OPLD, 0, 1, o(NO, 2'b10, 0, 2'b00, 4'b0000), "rst_from_trap");
        add(0, OPLD, 0, 1, o(FE, 2'b10, 0, 2'b00, 4'b0000), "ld2_fetch");
        add(0, OPLD, 0, 1, o(NO, 2'b10, 0, 2'b00, 4'b0000), "ld2_decode");
        add(0, OPLD, 0, 1, o(NO, 2'b10, 1, 2'b00, 4'b0000), "ld2_exec");
        add(0, OPLD, 0, 0, o(MM, 2'b10, 1, 2'b00, 4'b0000), "ld2_mem");
        add(1, OPLD, 0, 1, o(NO, 2'b10, 0, 2'b00, 4'b0000), "rst_mid_load");
        add(0, OPLD, 0, 0, o(FW, 2'b10, 0, 2'b00, 4'b0000), "post_rst_fetch");
        add(0, OPLD, 0, 0, o(FW, 2'b10, 0, 2'b00, 4'b0000), "post_rst_fetch2");

        rst = 1'b1; opcode = OPI; alu_zero = 1'b0; mem_ready = 1'b0;
        next_cycle();

        foreach (tbl[i]) begin
            rst       = tbl[i].rst;
            opcode    = tbl[i].opcode;
            alu_zero  = tbl[i].alu_zero;
            mem_ready = tbl[i].mem_ready;
            @(negedge clk);
            chk(tbl[i].name, 32'(act_outs()), 32'(tbl[i].exp));
            next_cycle();
        end

        // ready arrives on the last permitted cycle: no trap
        rst = 1'b1; mem_ready = 1'b0; opcode = OPI;
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < TMO_LIM - 1; k++) begin
            @(negedge clk);
            chk("wd_wait_req_trap", {30'd0, mem_req, trap}, 32'b10);
            next_cycle();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("wd_late_ready", {29'd0, ir_we, pc_we, trap}, 32'b110);
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("wd_no_trap_decode", {30'd0, mem_req, trap}, 32'b00);
        next_cycle();

        // no ready at all: trap once the limit is reached
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < TMO_LIM; k++) begin
            @(negedge clk);
            chk("wd_stall_req_trap", {30'd0, mem_req, trap}, 32'b10);
            next_cycle();
        end
        @(negedge clk);
        chk("wd_timeout", {29'd0, mem_req, trap, trap_cause}, 32'b011);
        next_cycle();
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("wd_trap_held", {28'd0, mem_req, ir_we, trap, trap_cause}, 32'b0011);
            next_cycle();
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("wd_rst_release", {29'd0, mem_req, trap, trap_cause}, 32'b100);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
